// File: rtl/mem_arbiter.sv
// Round-robin arbiter: serialises one outstanding request per core onto a single
// memory port and routes each completion back to its issuer.
//   state | meaning
//   IDLE  | pick next requester from rr_ptr, latch its fields
//   ISSUE | present latched request until memory accepts it
//   WAIT  | wait for the memory completion, capture read data
//   DONE  | pulse core_resp_valid for the served core, advance rr_ptr
module mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CORES-1:0]                 core_req_valid,
  input  logic [NUM_CORES-1:0]                 core_req_write,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_req_addr,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_req_wdata,
  output logic [NUM_CORES-1:0]                 core_resp_valid,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_resp_rdata,
  output logic                                 mem_req_valid,
  output logic                                 mem_req_write,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  output logic [DATA_WIDTH-1:0]                mem_req_wdata,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                mem_resp_rdata
);

  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int SW   = ID_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state, next_state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       lat_id;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic [SW-1:0]         idx_sum;
  logic [ID_W-1:0]       cand;

  // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_sum     = '0;
    cand        = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx_sum = {1'b0, rr_ptr} + SW'(i);
      if (idx_sum >= SW'(NUM_CORES))
        idx_sum = idx_sum - SW'(NUM_CORES);
      cand = idx_sum[ID_W-1:0];
      if (core_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      lat_id          <= '0;
      lat_write       <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      core_resp_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && grant_found) begin
        lat_id    <= grant_id;
        lat_write <= core_req_write[grant_id];
        lat_addr  <= core_req_addr[grant_id];
        lat_wdata <= core_req_wdata[grant_id];
      end
      if (state == S_WAIT && mem_resp_valid && !lat_write)
        core_resp_rdata[lat_id] <= mem_resp_rdata;
      if (state == S_DONE) begin
        if (lat_id == ID_W'(NUM_CORES - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= lat_id + ID_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant_found)    next_state = S_ISSUE;
      S_ISSUE: if (mem_req_ready)  next_state = S_WAIT;
      S_WAIT:  if (mem_resp_valid) next_state = S_DONE;
      S_DONE:                      next_state = S_IDLE;
      default:                     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    core_resp_valid = '0;
    mem_req_valid   = (state == S_ISSUE);
    mem_req_write   = lat_write;
    mem_req_addr    = lat_addr;
    mem_req_wdata   = lat_wdata;
    if (state == S_DONE)
      core_resp_valid[lat_id] = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks with a scoreboard of
// expected completions (core id and read data) popped on each response pulse.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
  } sb_t;

  logic                  clk;
  logic                  reset;
  logic [N-1:0]          core_req_valid;
  logic [N-1:0]          core_req_write;
  logic [N-1:0][AW-1:0]  core_req_addr;
  logic [N-1:0][DW-1:0]  core_req_wdata;
  logic [N-1:0]          core_resp_valid;
  logic [N-1:0][DW-1:0]  core_resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [AW-1:0]         mem_req_addr;
  logic [DW-1:0]         mem_req_wdata;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DW-1:0]         mem_resp_rdata;

  logic          manual_mode;
  logic          m_ready, m_resp;
  logic [DW-1:0] m_rdata;
  logic          auto_ready, auto_resp;
  logic [DW-1:0] auto_rdata;
  logic          pending;
  logic          pend_write;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] exp_rdata [N];

  sb_t sb_q[$];
  int  total;
  int  bad;

  assign mem_req_ready  = manual_mode ? m_ready : auto_ready;
  assign mem_resp_valid = manual_mode ? m_resp  : auto_resp;
  assign mem_resp_rdata = manual_mode ? m_rdata : auto_rdata;

  mem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_write(core_req_write),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: accept in ISSUE, respond in the following cycle.
  always @(negedge clk) begin
    auto_ready = 1'b0;
    auto_resp  = 1'b0;
    if (reset || manual_mode) begin
      pending = 1'b0;
    end else if (mem_req_valid) begin
      auto_ready = 1'b1;
      pending    = 1'b1;
      pend_write = mem_req_write;
      pend_addr  = mem_req_addr;
      pend_wdata = mem_req_wdata;
    end else if (pending) begin
      auto_resp  = 1'b1;
      auto_rdata = mem_model[pend_addr];
      if (pend_write) mem_model[pend_addr] = pend_wdata;
      pending = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int id, input logic [DW-1:0] rd);
    sb_t e;
    e.id = id;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (core_resp_valid !== '0) begin
      bad++; $display("FAIL reset_resp_valid: got %b want 0", core_resp_valid);
    end
    total++;
    if ({mem_req_valid, mem_req_write} !== 2'b00) begin
      bad++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_req_valid, mem_req_write});
    end
    total++;
    if ({mem_req_addr, mem_req_wdata} !== 16'h0) begin
      bad++; $display("FAIL reset_mem_data: got %h want 0000", {mem_req_addr, mem_req_wdata});
    end
    total++;
    if (core_resp_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", core_resp_rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
  endtask

  task automatic test_single_read();
    sb_t e;
    @(negedge clk);
    core_req_valid[1] = 1'b1;
    core_req_write[1] = 1'b0;
    core_req_addr[1]  = 8'h10;
    push_exp(1, 8'hA5);
    @(negedge clk);
    total++;
    if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 8'h10}) begin
      bad++; $display("FAIL single_issue: got v=%b w=%b a=%h want v=1 w=0 a=10",
                      mem_req_valid, mem_req_write, mem_req_addr);
    end
    @(negedge clk);
    total++;
    if (mem_req_valid !== 1'b0 || core_resp_valid !== '0) begin
      bad++; $display("FAIL single_wait: got v=%b resp=%b want 0 0", mem_req_valid, core_resp_valid);
    end
    @(negedge clk);
    total++;
    if (core_resp_valid !== 4'b0010) begin
      bad++; $display("FAIL single_pulse: got %b want 0010", core_resp_valid);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (core_resp_rdata[e.id] !== e.rdata) begin
        bad++; $display("FAIL single_rdata: got %h want %h", core_resp_rdata[e.id], e.rdata);
      end
      exp_rdata[e.id] = e.rdata;
    end
    core_req_valid[1] = 1'b0;
    @(negedge clk);
    total++;
    if (core_resp_valid !== '0) begin
      bad++; $display("FAIL single_one_pulse: got %b want 0", core_resp_valid);
    end
  endtask

  task automatic test_simultaneous();
    int  pulses [N];
    int  cycles;
    sb_t e;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_rdata[i] = '0;
      pulses[i] = 0;
      core_req_write[i] = 1'b0;
      core_req_addr[i]  = 8'(8'h40 + i);
      core_req_valid[i] = 1'b1;
      push_exp(i, 8'(8'h40 + i) ^ 8'h5A);
    end
    cycles = 0;
    while (sb_q.size() > 0 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (core_resp_valid != '0) begin
        for (int i = 0; i < N; i++) if (core_resp_valid[i]) pulses[i]++;
        e = sb_q.pop_front();
        total++;
        if (core_resp_valid !== 4'(1 << e.id)) begin
          bad++; $display("FAIL sim_grant: got %b want %b", core_resp_valid, 4'(1 << e.id));
        end
        total++;
        if (core_resp_rdata[e.id] !== e.rdata) begin
          bad++; $display("FAIL sim_rdata: core %0d got %h want %h", e.id, core_resp_rdata[e.id], e.rdata);
        end
        exp_rdata[e.id] = e.rdata;
        core_req_valid = core_req_valid & ~core_resp_valid;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sim_timeout: %0d responses outstanding want 0", sb_q.size());
      sb_q.delete();
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (pulses[i] != 1) begin
        bad++; $display("FAIL sim_pulse_count: core %0d got %0d want 1", i, pulses[i]);
      end
    end
    core_req_valid = '0;
    // Pointer must have wrapped to 0: core 0 beats core 3.
    core_req_addr[0] = 8'h50;
    core_req_addr[3] = 8'h53;
    core_req_valid[0] = 1'b1;
    core_req_valid[3] = 1'b1;
    push_exp(0, 8'h50 ^ 8'h5A);
    push_exp(3, 8'h53 ^ 8'h5A);
    cycles = 0;
    while (sb_q.size() > 0 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (core_resp_valid != '0) begin
        e = sb_q.pop_front();
        total++;
        if (core_resp_valid !== 4'(1 << e.id) || core_resp_rdata[e.id] !== e.rdata) begin
          bad++; $display("FAIL wrap_grant: got %b/%h want %b/%h", core_resp_valid,
                          core_resp_rdata[e.id], 4'(1 << e.id), e.rdata);
        end
        exp_rdata[e.id] = e.rdata;
        core_req_valid = core_req_valid & ~core_resp_valid;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL wrap_timeout: %0d responses outstanding want 0", sb_q.size());
      sb_q.delete();
    end
    core_req_valid = '0;
  endtask

  task automatic test_round_robin();
    int  cycles;
    sb_t e;
    @(negedge clk);
    core_req_write = '0;
    core_req_addr[2] = 8'h30;
    core_req_valid[2] = 1'b1;
    push_exp(2, 8'h30 ^ 8'h5A);
    cycles = 0;
    while (sb_q.size() > 0 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (core_resp_valid != '0) begin
        e = sb_q.pop_front();
        total++;
        if (core_resp_valid !== 4'(1 << e.id) || core_resp_rdata[e.id] !== e.rdata) begin
          bad++; $display("FAIL rr_first: got %b/%h want %b/%h", core_resp_valid,
                          core_resp_rdata[e.id], 4'(1 << e.id), e.rdata);
        end
        exp_rdata[e.id] = e.rdata;
        core_req_valid = core_req_valid & ~core_resp_valid;
      end
    end
    @(negedge clk);
    core_req_addr[1] = 8'h31;
    core_req_addr[3] = 8'h33;
    core_req_valid[1] = 1'b1;
    core_req_valid[3] = 1'b1;
    push_exp(3, 8'h33 ^ 8'h5A);
    push_exp(1, 8'h31 ^ 8'h5A);
    cycles = 0;
    while (sb_q.size() > 0 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (core_resp_valid != '0) begin
        e = sb_q.pop_front();
        total++;
        if (core_resp_valid !== 4'(1 << e.id) || core_resp_rdata[e.id] !== e.rdata) begin
          bad++; $display("FAIL rr_order: got %b/%h want %b/%h", core_resp_valid,
                          core_resp_rdata[e.id], 4'(1 << e.id), e.rdata);
        end
        exp_rdata[e.id] = e.rdata;
        core_req_valid = core_req_valid & ~core_resp_valid;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL rr_timeout: %0d responses outstanding want 0", sb_q.size());
      sb_q.delete();
    end
    core_req_valid = '0;
  endtask

  task automatic test_backpressure();
    sb_t e;
    manual_mode = 1'b1;
    m_ready = 1'b0;
    m_resp  = 1'b0;
    @(negedge clk);
    core_req_write[2] = 1'b1;
    core_req_addr[2]  = 8'h22;
    core_req_wdata[2] = 8'h3C;
    core_req_valid[2] = 1'b1;
    push_exp(2, exp_rdata[2]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 8'h22, 8'h3C}) begin
        bad++; $display("FAIL bp_stable[%0d]: got v=%b w=%b a=%h d=%h want v=1 w=1 a=22 d=3c",
                        i, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata);
      end
      if (i == 0) begin
        core_req_addr[2]  = 8'h99;
        core_req_wdata[2] = 8'hFF;
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL bp_accept: got mem_req_valid=%b want 0", mem_req_valid);
    end
    m_resp  = 1'b1;
    m_rdata = 8'hEE;
    @(negedge clk);
    m_resp = 1'b0;
    total++;
    if (core_resp_valid !== 4'b0100) begin
      bad++; $display("FAIL bp_pulse: got %b want 0100", core_resp_valid);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (core_resp_rdata[e.id] !== e.rdata) begin
        bad++; $display("FAIL bp_rdata_kept: got %h want %h", core_resp_rdata[e.id], e.rdata);
      end
    end
    core_req_valid = '0;
    core_req_write = '0;
    @(negedge clk);
    manual_mode = 1'b0;
  endtask

  task automatic test_stray_and_reset();
    manual_mode = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    m_resp  = 1'b1;
    m_rdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (core_resp_valid !== '0 || mem_req_valid !== 1'b0) begin
        bad++; $display("FAIL stray_idle[%0d]: got resp=%b v=%b want 0 0", i, core_resp_valid, mem_req_valid);
      end
    end
    m_resp = 1'b0;
    core_req_write[0] = 1'b0;
    core_req_addr[0]  = 8'h10;
    core_req_valid[0] = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 8'h10) begin
      bad++; $display("FAIL abort_issue: got v=%b a=%h want v=1 a=10", mem_req_valid, mem_req_addr);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    reset = 1'b1;
    core_req_valid = '0;
    @(negedge clk);
    total++;
    if ({core_resp_valid, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata} !== '0) begin
      bad++; $display("FAIL abort_outputs: got resp=%b v=%b w=%b a=%h d=%h want all 0",
                      core_resp_valid, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata);
    end
    total++;
    if (core_resp_rdata !== '0) begin
      bad++; $display("FAIL abort_rdata: got %h want 0", core_resp_rdata);
    end
    reset  = 1'b0;
    m_resp = 1'b1;
    m_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_resp = 1'b0;
      total++;
      if (core_resp_valid !== '0 || core_resp_rdata !== '0 || mem_req_valid !== 1'b0) begin
        bad++; $display("FAIL late_resp[%0d]: got resp=%b rdata=%h v=%b want 0",
                        i, core_resp_valid, core_resp_rdata, mem_req_valid);
      end
    end
    manual_mode = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    manual_mode = 1'b0;
    m_ready = 1'b0;
    m_resp  = 1'b0;
    m_rdata = '0;
    pending = 1'b0;
    pend_write = 1'b0;
    pend_addr  = '0;
    pend_wdata = '0;
    auto_ready = 1'b0;
    auto_resp  = 1'b0;
    auto_rdata = '0;
    core_req_valid = '0;
    core_req_write = '0;
    core_req_addr  = '0;
    core_req_wdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
    mem_model[8'h10] = 8'hA5;

    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_stray_and_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
